// File: rtl/noc_params.sv
// Shared NoC definitions: packet layout and the byte-framing constants used by
// both the serial transmit and receive sides.
package noc_params;

    localparam int X_W       = 4;
    localparam int Y_W       = 4;
    localparam int PAYLOAD_W = 24;

    typedef struct packed {
        logic [X_W-1:0]       x_dest;
        logic [Y_W-1:0]       y_dest;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

    localparam int PKT_SIZE       = $bits(packet_t);
    localparam int PKT_SIZE_BYTES = PKT_SIZE / 8;

    localparam logic [7:0] FRAME_DELIM = 8'h7E;
    localparam logic [7:0] FRAME_ESC   = 8'h7D;
    localparam logic [7:0] ESC_XOR     = 8'h20;

    // True for the two byte values that must be escaped inside a frame.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == FRAME_DELIM) || (b == FRAME_ESC);
    endfunction

endpackage

// File: rtl/packet_receiver_if.sv
// Byte-stream input and reassembled-packet output of the packet receiver.
interface packet_receiver_if;
    import noc_params::*;

    logic       valid_in;
    logic [7:0] rx_byte;
    packet_t    pkt;
    logic       valid_out;
    logic       frame_err;

    modport master (output valid_in, rx_byte, input pkt, valid_out, frame_err);
    modport slave  (input valid_in, rx_byte, output pkt, valid_out, frame_err);

endinterface

// File: rtl/packet_receiver.sv
// Deframes a 0x7E-delimited, 0x7D-escaped byte stream into packets; reports
// good packets with valid_out and discarded frames with frame_err.
module packet_receiver
    import noc_params::*;
(
    input  logic              clk,
    input  logic              rst,
    packet_receiver_if.slave  bus
);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_DATA = 2'd1,
        S_ESC  = 2'd2,
        S_END  = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(PKT_SIZE_BYTES);
    localparam logic [CNT_W-1:0]  ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PKT_SIZE_BYTES - 1);

    state_t                state_r;
    state_t                state_s;
    state_t                adv_state_s;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_s;
    logic [CNT_W-1:0]      adv_count_s;
    logic [PKT_SIZE-1:0]   asm_r;
    logic [PKT_SIZE-1:0]   asm_s;
    packet_t               pkt_r;
    logic                  valid_out_r;
    logic                  frame_err_r;
    logic                  deliver_s;
    logic                  err_s;
    logic                  store_en_s;
    logic [7:0]            store_byte_s;
    logic [7:0]            decoded_s;

    // Next state, byte counter and event decode for the accepted byte.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        store_en_s   = 1'b0;
        store_byte_s = bus.rx_byte;
        deliver_s    = 1'b0;
        err_s        = 1'b0;
        decoded_s    = bus.rx_byte ^ ESC_XOR;
        // Where a stored data byte leads: the end delimiter follows the last one.
        adv_state_s  = (count_r == LAST_IDX) ? S_END : S_DATA;
        adv_count_s  = (count_r == LAST_IDX) ? ZERO_CNT : (count_r + ONE_CNT);

        if (bus.valid_in) begin
            case (state_r)
                S_HUNT: begin
                    if (bus.rx_byte == FRAME_DELIM) begin
                        state_s = S_DATA;
                        count_s = ZERO_CNT;
                    end else begin
                        state_s = S_HUNT;
                    end
                end
                S_DATA: begin
                    if (bus.rx_byte == FRAME_DELIM) begin
                        err_s   = (count_r != ZERO_CNT);
                        state_s = S_DATA;
                        count_s = ZERO_CNT;
                    end else if (bus.rx_byte == FRAME_ESC) begin
                        state_s = S_ESC;
                    end else begin
                        store_en_s   = 1'b1;
                        store_byte_s = bus.rx_byte;
                        state_s      = adv_state_s;
                        count_s      = adv_count_s;
                    end
                end
                S_ESC: begin
                    if (bus.rx_byte == FRAME_DELIM) begin
                        err_s   = 1'b1;
                        state_s = S_DATA;
                        count_s = ZERO_CNT;
                    end else if (is_ctrl_byte(decoded_s)) begin
                        store_en_s   = 1'b1;
                        store_byte_s = decoded_s;
                        state_s      = adv_state_s;
                        count_s      = adv_count_s;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_HUNT;
                        count_s = ZERO_CNT;
                    end
                end
                S_END: begin
                    if (bus.rx_byte == FRAME_DELIM) begin
                        deliver_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    state_s = S_HUNT;
                    count_s = ZERO_CNT;
                end
                default: begin
                    state_s = S_HUNT;
                    count_s = ZERO_CNT;
                end
            endcase
        end else begin
            state_s = state_r;
            count_s = count_r;
        end
    end

    // Byte k of the frame lands MSB-first in the assembly register.
    always_comb begin
        asm_s = asm_r;
        for (int k = 0; k < PKT_SIZE_BYTES; k++) begin
            asm_s[PKT_SIZE-1-8*k -: 8] = (store_en_s && (count_r == CNT_W'(k)))
                                         ? store_byte_s
                                         : asm_r[PKT_SIZE-1-8*k -: 8];
        end
    end

    // State, assembly and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_HUNT;
            count_r     <= ZERO_CNT;
            asm_r       <= {PKT_SIZE{1'b0}};
            pkt_r       <= packet_t'({PKT_SIZE{1'b0}});
            valid_out_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            asm_r       <= asm_s;
            valid_out_r <= deliver_s;
            frame_err_r <= err_s;
            if (deliver_s) begin
                pkt_r <= packet_t'(asm_r);
            end else begin
                pkt_r <= pkt_r;
            end
        end
    end

    assign bus.pkt       = pkt_r;
    assign bus.valid_out = valid_out_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_packet_receiver.sv
// Self-checking bench for packet_receiver: directed frame table, reset and
// latency sequences, then random framed traffic against a frame-level model.
module tb_packet_receiver;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    packet_receiver_if bus ();

    packet_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    int vcnt = 0, ecnt = 0, overlap = 0, stray = 0;
    packet_t prev_pkt;

    typedef struct {
        logic [95:0] seq;
        int          len;
        int          exp_v;
        int          exp_e;
        logic [31:0] exp_pkt;
    } vec_t;

    vec_t vecs [9];

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_pkt <= bus.pkt;
        end else begin
            if (bus.valid_out) vcnt <= vcnt + 1;
            if (bus.frame_err) ecnt <= ecnt + 1;
            if (bus.valid_out && bus.frame_err) overlap <= overlap + 1;
            if (!bus.valid_out && (bus.pkt !== prev_pkt)) stray <= stray + 1;
            prev_pkt <= bus.pkt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            bus.valid_in = 1'b0;
            bus.rx_byte  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b1;
        bus.rx_byte  = b;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Escape-encode one data byte onto a byte queue.
    task automatic push_enc(inout logic [7:0] q[$], input logic [7:0] b);
        if (is_ctrl_byte(b)) begin
            q.push_back(FRAME_ESC);
            q.push_back(b ^ ESC_XOR);
        end else begin
            q.push_back(b);
        end
    endtask

    initial begin
        int v0, e0;
        logic [31:0] ref_pkt;
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] p;
        int kind, k, exp_v, exp_e;

        vecs[0] = '{96'h7E12345678_7E000000000000, 6,  1, 0, 32'h12345678};
        vecs[1] = '{96'h7E7D5E117D5D227E_00000000, 8,  1, 0, 32'h7E117D22};
        vecs[2] = '{96'h7EAABB7E010203047E_000000, 9,  1, 1, 32'h01020304};
        vecs[3] = '{96'h7E5566778811_000000000000, 6,  0, 1, 32'h01020304};
        vecs[4] = '{96'h7E017D41_0000000000000000, 4,  0, 1, 32'h01020304};
        vecs[5] = '{96'h7E017D7E9ABCDEF07E_000000, 9,  1, 1, 32'h9ABCDEF0};
        vecs[6] = '{96'h7E7E7E0A0B0C0D7E_00000000, 8,  1, 0, 32'h0A0B0C0D};
        vecs[7] = '{96'h7EA1A2A3A47E7EB1B2B3B47E,  12, 2, 0, 32'hB1B2B3B4};
        vecs[8] = '{96'h33447E7D5D7D5E01027E_0000, 10, 1, 0, 32'h7D7E0102};

        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.rx_byte  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pkt", 32'(bus.pkt), 32'h0);
        check("reset_valid_out", 32'(bus.valid_out), 32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            v0 = vcnt; e0 = ecnt;
            for (int j = 0; j < vecs[i].len; j++)
                send_byte(vecs[i].seq[95-8*j -: 8], $urandom_range(0, 2));
            idle(3);
            check($sformatf("vec%0d_valid_count", i), 32'(vcnt - v0), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d_err_count", i), 32'(ecnt - e0), 32'(vecs[i].exp_e));
            check($sformatf("vec%0d_pkt", i), 32'(bus.pkt), vecs[i].exp_pkt);
        end

        // Reset in the middle of a frame discards it silently and clears pkt.
        send_byte(8'h7E, 0);
        send_byte(8'h01, 1);
        send_byte(8'h02, 0);
        v0 = vcnt; e0 = ecnt;
        rst = 1'b1;
        idle(2);
        check("midrst_pkt_cleared", 32'(bus.pkt), 32'h0);
        rst = 1'b0;
        idle(3);
        send_byte(8'h03, 0);
        send_byte(8'h04, 2);
        idle(2);
        check("midrst_no_valid", 32'(vcnt - v0), 32'h0);
        check("midrst_no_err", 32'(ecnt - e0), 32'h0);

        // Fresh frame after reset; valid_out is a one-cycle pulse after the end edge.
        send_byte(8'h7E, 0);
        send_byte(8'hC1, 0);
        send_byte(8'hC2, 3);
        send_byte(8'hC3, 0);
        send_byte(8'hC4, 1);
        send_byte(8'h7E, 0);
        check("latency_valid_out", 32'(bus.valid_out), 32'h1);
        check("latency_pkt", 32'(bus.pkt), 32'hC1C2C3C4);
        idle(1);
        check("pulse_width", 32'(bus.valid_out), 32'h0);
        ref_pkt = 32'hC1C2C3C4;

        for (int f = 0; f < 40; f++) begin
            q.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == FRAME_DELIM) b = 8'h00;
                q.push_back(b);
            end
            q.push_back(FRAME_DELIM);
            p = $urandom;
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 3) == 0)
                    p[31-8*j -: 8] = ($urandom_range(0, 1) == 1) ? FRAME_DELIM : FRAME_ESC;
            kind = $urandom_range(0, 2);
            if (kind == 2) begin
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) push_enc(q, p[31-8*j -: 8]);
                q.push_back(FRAME_ESC);
                do b = 8'($urandom);
                while (b == FRAME_DELIM || is_ctrl_byte(b ^ ESC_XOR));
                q.push_back(b);
            end else begin
                for (int j = 0; j < 4; j++) push_enc(q, p[31-8*j -: 8]);
                if (kind == 0) begin
                    q.push_back(FRAME_DELIM);
                end else begin
                    do b = 8'($urandom);
                    while (b == FRAME_DELIM);
                    q.push_back(b);
                end
            end
            exp_v = (kind == 0) ? 1 : 0;
            exp_e = (kind == 0) ? 0 : 1;
            if (kind == 0) ref_pkt = p;

            v0 = vcnt; e0 = ecnt;
            foreach (q[j]) send_byte(q[j], $urandom_range(0, 3));
            idle(3);
            check($sformatf("rand%0d_k%0d_valid", f, kind), 32'(vcnt - v0), 32'(exp_v));
            check($sformatf("rand%0d_k%0d_err", f, kind), 32'(ecnt - e0), 32'(exp_e));
            check($sformatf("rand%0d_k%0d_pkt", f, kind), 32'(bus.pkt), ref_pkt);
        end

        check("no_valid_err_overlap", 32'(overlap), 32'h0);
        check("pkt_only_with_valid", 32'(stray), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 Parameters: none local; PKT_SIZE, PKT_SIZE_BYTES and packet_t SHALL come from package noc_params.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 valid_in  input  1  rx_byte valid this cycle; no backpressure, every valid byte is consumed.
REQ-005 rx_byte  input  8  serial input byte.
REQ-006 pkt  output  packet_t  last good reassembled packet; held stable between updates.
REQ-007 valid_out  output  1  one-cycle pulse: pkt updated with a new good packet.
REQ-008 frame_err  output  1  one-cycle pulse: malformed frame discarded.

Function
REQ-009 Framing SHALL be: 0x7E start, PKT_SIZE_BYTES data bytes, 0x7E end; 0x7E/0x7D data is sent as 0x7D then (byte XOR 0x20).
REQ-010 Byte order SHALL be MSB-first: data byte k fills bits [PKT_SIZE-1-8k -: 8] of {x_dest, y_dest, payload}; PKT_SIZE SHALL be a multiple of 8.
REQ-011 States SHALL be S_HUNT, S_DATA, S_ESC, S_END; state advances only on cycles with valid_in=1.
REQ-012 S_HUNT: 0x7E -> S_DATA with byte count 0; any other byte is dropped silently.
REQ-013 S_DATA, 0x7E at count 0: treated as a repeated start; stay in S_DATA, no error.
REQ-014 S_DATA, 0x7E at count >0: frame_err pulse; treat as new start (S_DATA, count 0).
REQ-015 S_DATA, 0x7D: -> S_ESC, count unchanged.
REQ-016 S_DATA, other byte: store at current count and increment; -> S_END after byte PKT_SIZE_BYTES-1, else stay in S_DATA.
REQ-017 S_ESC: decoded = rx_byte XOR 0x20; if decoded is 0x7E or 0x7D, store it, increment, apply the REQ-016 transition.
REQ-018 S_ESC, rx_byte 0x7E: frame_err; new start (S_DATA, count 0).
REQ-019 S_ESC, decoded byte not 0x7E/0x7D: frame_err; -> S_HUNT.
REQ-020 S_END, 0x7E: register the assembled packet into pkt, pulse valid_out in the next cycle; -> S_HUNT.
REQ-021 S_END, non-0x7E (overlong frame): frame_err; -> S_HUNT; pkt unchanged.
REQ-022 Latency: valid_out SHALL rise the cycle after the clock edge that accepts the end delimiter.
REQ-023 pkt SHALL change only with valid_out; discarded frames never modify pkt.
REQ-024 valid_out and frame_err SHALL never be high in the same cycle.
REQ-025 Gaps (valid_in=0) of any length are allowed anywhere in a frame; state and count hold.
REQ-026 The byte counter SHALL be $clog2(PKT_SIZE_BYTES) bits and never exceed PKT_SIZE_BYTES-1.

Reset
REQ-027 On rst: state=S_HUNT, count=0, assembly register=0, pkt=0, valid_out=0, frame_err=0.
REQ-028 rst mid-frame SHALL discard the partial frame with no valid_out or frame_err pulse; the next 0x7E starts a fresh frame.

Structure
REQ-029 Framing constants FRAME_DELIM=8'h7E, FRAME_ESC=8'h7D, ESC_XOR=8'h20 SHALL be added to noc_params and shared with the transmit side.
REQ-030 The state enum SHALL stay local; the block SHALL be one module with no sub-modules.

Verification
REQ-031 Clean frame, payload without 0x7E/0x7D -> one valid_out; pkt equals the sent packet; frame_err stays 0.
REQ-032 Payload containing 0x7E and 0x7D, sent as 7D 5E / 7D 5D -> pkt holds 0x7E/0x7D at the correct byte positions.
REQ-033 0x7E after 2 data bytes, then a full good frame -> one frame_err, then one valid_out with the second packet.
REQ-034 Extra byte 0x11 in place of the end delimiter -> frame_err; pkt keeps its previous value.
REQ-035 Escape 7D 41, and separately 7D then 7E -> frame_err each; the second case's following full frame is received.
REQ-036 Back-to-back frames sharing no idle (7E..7E 7E..7E) plus random valid_in gaps -> two valid_out; rst mid-frame -> no output.
